// File: rtl/div_share_ctrl.sv
// div_share_ctrl
//   Shares a single unsigned divide unit between two requesters. An idle
//   controller grants one requester (round-robin on ties), drives the
//   captured operands onto div_a/div_b, waits WAIT_CYCLES for the divider
//   to settle, then returns quotient/remainder (or a divide-by-zero flag)
//   on the granted requester's response channel.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid/ready/a/b      request channel N (N = 0, 1); ready is combinational
//   respN_valid/ready         response channel N
//   respN_quotient/remainder  registered result for requester N
//   respN_dbz                 denominator of the returned operation was zero
//   div_a, div_b              registered operands to the divide unit
//   div_quotient/remainder    divide unit outputs
//   busy                      registered, high while an operation is in flight
module div_share_ctrl #(
  parameter int WIDTH       = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_quotient,
  output logic [WIDTH-1:0] resp0_remainder,
  output logic             resp0_dbz,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_quotient,
  output logic [WIDTH-1:0] resp1_remainder,
  output logic             resp1_dbz,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             busy
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last;      // 1: requester 1 was served most recently
  logic             gnt;       // owner of the operation in flight
  logic             pick;      // requester that would win arbitration now
  logic             any_valid;
  logic [3:0]       cnt;
  logic [2*WIDTH:0] res;       // {dbz, quotient, remainder}

  // A zero denominator forces a clean zero result regardless of what the
  // divide unit produces for that case.
  function automatic logic [2*WIDTH:0] guard_result(
    input logic [WIDTH-1:0] den,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] r
  );
    logic [2*WIDTH:0] out;
    if (den == '0) out = {1'b1, {(2*WIDTH){1'b0}}};
    else           out = {1'b0, q, r};
    return out;
  endfunction

  assign any_valid = req0_valid | req1_valid;
  // On a tie the requester not served last wins; otherwise the sole valid one.
  assign pick      = (req0_valid && req1_valid) ? ~last : req1_valid;
  assign res       = guard_result(div_b, div_quotient, div_remainder);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      S_IDLE: begin
        if (any_valid) begin
          req0_ready = ~pick;
          req1_ready = pick;
          state_nxt  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (gnt ? resp1_ready : resp0_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last            <= 1'b1;
      gnt             <= 1'b0;
      cnt             <= 4'd0;
      busy            <= 1'b0;
      div_a           <= '0;
      div_b           <= '0;
      resp0_valid     <= 1'b0;
      resp0_quotient  <= '0;
      resp0_remainder <= '0;
      resp0_dbz       <= 1'b0;
      resp1_valid     <= 1'b0;
      resp1_quotient  <= '0;
      resp1_remainder <= '0;
      resp1_dbz       <= 1'b0;
    end else begin
      busy <= (state_nxt != S_IDLE);
      case (state)
        // Issue: latch the winner's operands onto the divider inputs
        S_IDLE: begin
          if (any_valid) begin
            div_a <= pick ? req1_a : req0_a;
            div_b <= pick ? req1_b : req0_b;
            gnt   <= pick;
            cnt   <= CNT_LOAD;
          end
        end
        // Settle: operands held, result captured once the count expires
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!gnt) begin
            {resp0_dbz, resp0_quotient, resp0_remainder} <= res;
            resp0_valid <= 1'b1;
          end else begin
            {resp1_dbz, resp1_quotient, resp1_remainder} <= res;
            resp1_valid <= 1'b1;
          end
        end
        // Return: hold the result until the owner takes it
        S_RESP: begin
          if (!gnt && resp0_ready) begin
            resp0_valid <= 1'b0;
            last        <= 1'b0;
          end else if (gnt && resp1_ready) begin
            resp1_valid <= 1'b0;
            last        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_share_ctrl.sv
module tb_div_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  // instance with WAIT_CYCLES = 1
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       resp0_valid, resp0_ready, resp0_dbz;
  logic       resp1_valid, resp1_ready, resp1_dbz;
  logic [7:0] resp0_quotient, resp0_remainder, resp1_quotient, resp1_remainder;
  logic [7:0] div_a, div_b, div_quotient, div_remainder;
  logic       busy;
  // instance with WAIT_CYCLES = 3
  logic       t_req0_valid, t_req0_ready, t_req1_valid, t_req1_ready;
  logic [7:0] t_req0_a, t_req0_b, t_req1_a, t_req1_b;
  logic       t_resp0_valid, t_resp0_ready, t_resp0_dbz;
  logic       t_resp1_valid, t_resp1_ready, t_resp1_dbz;
  logic [7:0] t_resp0_quotient, t_resp0_remainder, t_resp1_quotient, t_resp1_remainder;
  logic [7:0] t_div_a, t_div_b, t_div_quotient, t_div_remainder;
  logic       t_busy;
  logic [3:0] t_age;
  logic [15:0] t_seen;

  int total = 0;
  int bad   = 0;
  bit mon_on = 1'b0;

  div_share_ctrl #(.WIDTH(8), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_quotient(resp0_quotient),
    .resp0_remainder(resp0_remainder), .resp0_dbz(resp0_dbz),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_quotient(resp1_quotient),
    .resp1_remainder(resp1_remainder), .resp1_dbz(resp1_dbz),
    .div_a(div_a), .div_b(div_b), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .busy(busy)
  );

  div_share_ctrl #(.WIDTH(8), .WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst),
    .req0_valid(t_req0_valid), .req0_ready(t_req0_ready), .req0_a(t_req0_a), .req0_b(t_req0_b),
    .req1_valid(t_req1_valid), .req1_ready(t_req1_ready), .req1_a(t_req1_a), .req1_b(t_req1_b),
    .resp0_valid(t_resp0_valid), .resp0_ready(t_resp0_ready), .resp0_quotient(t_resp0_quotient),
    .resp0_remainder(t_resp0_remainder), .resp0_dbz(t_resp0_dbz),
    .resp1_valid(t_resp1_valid), .resp1_ready(t_resp1_ready), .resp1_quotient(t_resp1_quotient),
    .resp1_remainder(t_resp1_remainder), .resp1_dbz(t_resp1_dbz),
    .div_a(t_div_a), .div_b(t_div_b), .div_quotient(t_div_quotient),
    .div_remainder(t_div_remainder), .busy(t_busy)
  );

  // Combinational divider; a zero denominator drives all ones.
  assign div_quotient  = (div_b == 8'd0) ? 8'hFF : div_a / div_b;
  assign div_remainder = (div_b == 8'd0) ? 8'hFF : div_a % div_b;

  // Slow divider: garbage until its inputs have been stable long enough.
  always @(negedge clk) begin
    if ({t_div_a, t_div_b} !== t_seen) begin
      t_seen <= {t_div_a, t_div_b};
      t_age  <= 4'd0;
    end else if (t_age != 4'd15) begin
      t_age  <= t_age + 4'd1;
    end
  end
  assign t_div_quotient  = (t_age >= 4'd2) ? ((t_div_b == 8'd0) ? 8'hFF : t_div_a / t_div_b) : 8'hEE;
  assign t_div_remainder = (t_age >= 4'd2) ? ((t_div_b == 8'd0) ? 8'hFF : t_div_a % t_div_b) : 8'hEE;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Reference model for the WAIT_CYCLES=1 instance: one outstanding
  // operation, result due two cycles after its handshake cycle.
  initial begin
    bit       m_busy, m_who, m_last, exp_v, exp_r0, exp_r1;
    int       m_age;
    bit [7:0] m_a, m_b, m_q, m_r;
    bit       m_dbz;
    m_busy = 0; m_who = 0; m_last = 1; m_age = 0;
    m_a = 0; m_b = 0; m_q = 0; m_r = 0; m_dbz = 0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (m_busy) m_age++;
        exp_v = m_busy && (m_age >= 2);
        chk("m_rv0", 32'(resp0_valid), 32'(exp_v && !m_who));
        chk("m_rv1", 32'(resp1_valid), 32'(exp_v && m_who));
        chk("m_busy", 32'(busy), 32'(m_busy));
        if (m_busy) begin
          chk("m_diva", 32'(div_a), 32'(m_a));
          chk("m_divb", 32'(div_b), 32'(m_b));
        end
        if (exp_v) begin
          if (!m_who) begin
            chk("m_q0", 32'(resp0_quotient), 32'(m_q));
            chk("m_r0", 32'(resp0_remainder), 32'(m_r));
            chk("m_z0", 32'(resp0_dbz), 32'(m_dbz));
          end else begin
            chk("m_q1", 32'(resp1_quotient), 32'(m_q));
            chk("m_r1", 32'(resp1_remainder), 32'(m_r));
            chk("m_z1", 32'(resp1_dbz), 32'(m_dbz));
          end
        end
        exp_r0 = 0;
        exp_r1 = 0;
        if (!m_busy) begin
          if (req0_valid && req1_valid) begin
            if (m_last) exp_r0 = 1;
            else        exp_r1 = 1;
          end else if (req0_valid) exp_r0 = 1;
          else if (req1_valid)     exp_r1 = 1;
        end
        chk("m_rdy0", 32'(req0_ready), 32'(exp_r0));
        chk("m_rdy1", 32'(req1_ready), 32'(exp_r1));
        if (rst) begin
          m_busy = 0;
          m_last = 1;
        end else if (exp_v && (m_who ? resp1_ready : resp0_ready)) begin
          m_busy = 0;
          m_last = m_who;
        end else if (exp_r0 || exp_r1) begin
          m_who  = exp_r1;
          m_a    = exp_r1 ? req1_a : req0_a;
          m_b    = exp_r1 ? req1_b : req0_b;
          m_dbz  = (m_b == 0);
          m_q    = m_dbz ? 8'd0 : m_a / m_b;
          m_r    = m_dbz ? 8'd0 : m_a % m_b;
          m_busy = 1;
          m_age  = 0;
        end
      end
    end
  end

  initial begin
    rst = 1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req1_valid = 0; req1_a = 0; req1_b = 0;
    resp0_ready = 1; resp1_ready = 1;
    t_req0_valid = 0; t_req0_a = 0; t_req0_b = 0; t_req1_valid = 0; t_req1_a = 0; t_req1_b = 0;
    t_resp0_ready = 1; t_resp1_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_rv0", 32'(resp0_valid), 0);
    chk("rst_rv1", 32'(resp1_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_diva", 32'(div_a), 0);
    chk("rst_q0", 32'(resp0_quotient), 0);
    chk("rst_z1", 32'(resp1_dbz), 0);
    chk("rst_tbusy", 32'(t_busy), 0);
    mon_on = 1;
    nxt();

    // single op 200/7
    req0_valid = 1; req0_a = 200; req0_b = 7;
    @(negedge clk);
    chk("t1_rdy0", 32'(req0_ready), 1);
    chk("t1_rdy1", 32'(req1_ready), 0);
    nxt(); req0_valid = 0;
    @(negedge clk);
    chk("t1_wait_rv0", 32'(resp0_valid), 0);
    chk("t1_wait_busy", 32'(busy), 1);
    nxt();
    @(negedge clk);
    chk("t1_rv0", 32'(resp0_valid), 1);
    chk("t1_q0", 32'(resp0_quotient), 28);
    chk("t1_r0", 32'(resp0_remainder), 4);
    chk("t1_z0", 32'(resp0_dbz), 0);
    chk("t1_rv1", 32'(resp1_valid), 0);
    nxt();

    // divide by zero on requester 1
    req1_valid = 1; req1_a = 55; req1_b = 0;
    @(negedge clk);
    chk("t2_rdy1", 32'(req1_ready), 1);
    nxt(); req1_valid = 0;
    nxt();
    @(negedge clk);
    chk("t2_rv1", 32'(resp1_valid), 1);
    chk("t2_q1", 32'(resp1_quotient), 0);
    chk("t2_r1", 32'(resp1_remainder), 0);
    chk("t2_z1", 32'(resp1_dbz), 1);
    nxt();

    // ties from reset, twice: requester 0 first each time
    rst = 1; nxt(); rst = 0;
    for (int p = 0; p < 2; p++) begin
      req0_valid = 1; req0_a = 100; req0_b = 10;
      req1_valid = 1; req1_a = 9;   req1_b = 4;
      @(negedge clk);
      chk("tie_rdy0", 32'(req0_ready), 1);
      chk("tie_rdy1", 32'(req1_ready), 0);
      nxt(); req0_valid = 0;
      @(negedge clk);
      chk("tie_wait_rdy1", 32'(req1_ready), 0);
      nxt();
      @(negedge clk);
      chk("tie_q0", 32'(resp0_quotient), 10);
      chk("tie_r0", 32'(resp0_remainder), 0);
      nxt();
      @(negedge clk);
      chk("tie_rdy1_idle", 32'(req1_ready), 1);
      nxt(); req1_valid = 0;
      nxt();
      @(negedge clk);
      chk("tie_rv1", 32'(resp1_valid), 1);
      chk("tie_q1", 32'(resp1_quotient), 2);
      chk("tie_r1", 32'(resp1_remainder), 1);
      nxt();
    end

    // backpressure on response 0 with requester 1 waiting
    resp0_ready = 0;
    req0_valid = 1; req0_a = 50; req0_b = 3;
    @(negedge clk);
    chk("bp_rdy0", 32'(req0_ready), 1);
    nxt(); req0_valid = 0;
    req1_valid = 1; req1_a = 77; req1_b = 5;
    nxt();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rv0", 32'(resp0_valid), 1);
      chk("bp_q0", 32'(resp0_quotient), 16);
      chk("bp_r0", 32'(resp0_remainder), 2);
      chk("bp_rdy1", 32'(req1_ready), 0);
      chk("bp_busy", 32'(busy), 1);
      nxt();
    end
    resp0_ready = 1;
    nxt();
    @(negedge clk);
    chk("bp_rdy1_idle", 32'(req1_ready), 1);
    chk("bp_busy_idle", 32'(busy), 0);
    nxt(); req1_valid = 0;
    nxt();
    @(negedge clk);
    chk("bp_q1", 32'(resp1_quotient), 15);
    chk("bp_r1", 32'(resp1_remainder), 2);
    nxt();

    // reset while waiting discards the operation
    req0_valid = 1; req0_a = 9; req0_b = 2;
    nxt(); req0_valid = 0;
    rst = 1; nxt(); rst = 0;
    @(negedge clk);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_rv0", 32'(resp0_valid), 0);
    chk("mr_rv1", 32'(resp1_valid), 0);
    nxt();
    @(negedge clk);
    chk("mr_rv0_late", 32'(resp0_valid), 0);
    nxt();
    req0_valid = 1; req0_a = 200; req0_b = 7;
    @(negedge clk);
    chk("mr_rdy0", 32'(req0_ready), 1);
    nxt(); req0_valid = 0;
    nxt();
    @(negedge clk);
    chk("mr_q0", 32'(resp0_quotient), 28);
    chk("mr_r0", 32'(resp0_remainder), 4);
    nxt();

    // slow divider instance: 250/16 with WAIT_CYCLES = 3
    t_req0_valid = 1; t_req0_a = 250; t_req0_b = 16;
    @(negedge clk);
    chk("w3_rdy0", 32'(t_req0_ready), 1);
    nxt(); t_req0_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("w3_diva", 32'(t_div_a), 250);
      chk("w3_divb", 32'(t_div_b), 16);
      chk("w3_rv0", 32'(t_resp0_valid), 0);
      chk("w3_busy", 32'(t_busy), 1);
      nxt();
    end
    @(negedge clk);
    chk("w3_rv0_up", 32'(t_resp0_valid), 1);
    chk("w3_q0", 32'(t_resp0_quotient), 15);
    chk("w3_r0", 32'(t_resp0_remainder), 10);
    chk("w3_z0", 32'(t_resp0_dbz), 0);
    nxt();

    // random traffic against the reference model
    for (int n = 0; n < 3000; n++) begin
      req0_valid  = ($urandom_range(0, 2) != 0);
      req1_valid  = ($urandom_range(0, 2) != 0);
      req0_a      = 8'($urandom);
      req1_a      = 8'($urandom);
      req0_b      = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      req1_b      = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);
      rst         = ($urandom_range(0, 199) == 0);
      nxt();
    end
    rst = 0; req0_valid = 0; req1_valid = 0; resp0_ready = 1; resp1_ready = 1;
    repeat (4) nxt();
    mon_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
